// File: rtl/fft_stage_sched_if.sv
// Bundles the control and sample-RAM/butterfly addressing signals of the FFT stage
// scheduler. The master side is the scheduler. The slave side is the FFT top-level
// control together with the RAM/butterfly datapath.
interface fft_stage_sched_if #(
    parameter int LOG2N = 3
);
    logic             start;
    logic             busy;
    logic             done;
    logic             result_bank;
    logic [LOG2N-1:0] stage;
    logic             rd_en;
    logic             rd_bank;
    logic [LOG2N-1:0] rd_addr_p;
    logic [LOG2N-1:0] rd_addr_q;
    logic [LOG2N-2:0] tw_addr;
    logic             bf_en;
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr_p;
    logic [LOG2N-1:0] wr_addr_q;

    modport master (
        input  start,
        output busy, done, result_bank, stage,
        output rd_en, rd_bank, rd_addr_p, rd_addr_q, tw_addr,
        output bf_en, wr_en, wr_addr_p, wr_addr_q
    );

    modport slave (
        output start,
        input  busy, done, result_bank, stage,
        input  rd_en, rd_bank, rd_addr_p, rd_addr_q, tw_addr,
        input  bf_en, wr_en, wr_addr_p, wr_addr_q
    );
endinterface

// File: rtl/fft_stage_sched.sv
// Address and strobe scheduler for a radix-2 DIT in-place FFT built around a single
// butterfly unit.
// For each stage, the scheduler issues N/2 operand pairs with their twiddle indices,
// one pair per cycle. It then drains the read + butterfly pipeline, so every write
// of that stage lands before the next stage starts reading. The ping-pong RAM bank
// flips after each stage.
// RD_LAT and BFLY_LAT must each be at least 1.
module fft_stage_sched #(
    parameter int LOG2N    = 3,
    parameter int RD_LAT   = 1,
    parameter int BFLY_LAT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_stage_sched_if.master    bus
);

    localparam int L  = RD_LAT + BFLY_LAT;
    localparam int DW = (L > 1) ? $clog2(L) : 1;

    localparam logic [LOG2N-2:0] K_LAST     = '1;
    localparam logic [LOG2N-1:0] STAGE_LAST = LOG2N'(LOG2N - 1);
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(L - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [LOG2N-1:0] stage_q, stage_d;
    logic [LOG2N-2:0] k_q, k_d;
    logic [DW-1:0]    drainCnt_q, drainCnt_d;
    logic             rdBank_q, rdBank_d;
    logic             resultBank_q, resultBank_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rdEn_q, rdEn_d;
    logic [LOG2N-1:0] rdAddrP_q, rdAddrP_d;
    logic [LOG2N-1:0] rdAddrQ_q, rdAddrQ_d;
    logic [LOG2N-2:0] twAddr_q, twAddr_d;

    logic             issue;
    logic [LOG2N-1:0] issueStage;
    logic [LOG2N-2:0] issueK;

    logic [L-1:0]     rdEnPipe_q;
    logic [LOG2N-1:0] addrPPipe_q [L];
    logic [LOG2N-1:0] addrQPipe_q [L];

    // To form the upper operand index, the pair counter is split at bit 'stage' and
    // a zero is inserted there. The partner operand sits 'half' entries above it.
    function automatic logic [LOG2N-1:0] calcAddrP(input logic [LOG2N-1:0] s,
                                                   input logic [LOG2N-2:0] k);
        int ki;
        int si;
        int ji;
        ki = int'(k);
        si = int'(s);
        ji = ki & ((1 << si) - 1);
        return LOG2N'(((ki >> si) << (si + 1)) | ji);
    endfunction

    function automatic logic [LOG2N-2:0] calcTw(input logic [LOG2N-1:0] s,
                                                input logic [LOG2N-2:0] k);
        int ki;
        int si;
        int ji;
        ki = int'(k);
        si = int'(s);
        ji = ki & ((1 << si) - 1);
        return (LOG2N-1)'(ji << (LOG2N - 1 - si));
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Every output is computed for the cycle after this edge, so all outputs leave the chip registered.
    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        k_d          = k_q;
        drainCnt_d   = drainCnt_q;
        rdBank_d     = rdBank_q;
        resultBank_d = resultBank_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        issue        = 1'b0;
        issueStage   = stage_q;
        issueK       = k_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = ISSUE;
                    stage_d    = '0;
                    rdBank_d   = 1'b0;
                    k_d        = '0;
                    busy_d     = 1'b1;
                    issue      = 1'b1;
                    issueStage = '0;
                    issueK     = '0;
                end
            end
            ISSUE: begin
                busy_d = 1'b1;
                if (k_q == K_LAST) begin
                    state_d    = DRAIN;
                    drainCnt_d = '0;
                end else begin
                    k_d    = k_q + 1'b1;
                    issue  = 1'b1;
                    issueK = k_q + 1'b1;
                end
            end
            DRAIN: begin
                busy_d = 1'b1;
                if (drainCnt_q == DRAIN_LAST) begin
                    if (stage_q == STAGE_LAST) begin
                        state_d      = DONE;
                        done_d       = 1'b1;
                        resultBank_d = ~rdBank_q;
                    end else begin
                        state_d    = ISSUE;
                        stage_d    = stage_q + 1'b1;
                        rdBank_d   = ~rdBank_q;
                        k_d        = '0;
                        issue      = 1'b1;
                        issueStage = stage_q + 1'b1;
                        issueK     = '0;
                    end
                end else begin
                    drainCnt_d = drainCnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rdEn_d    = issue;
        rdAddrP_d = issue ? calcAddrP(issueStage, issueK) : '0;
        rdAddrQ_d = issue ? (calcAddrP(issueStage, issueK) + (LOG2N'(1) << issueStage)) : '0;
        twAddr_d  = issue ? calcTw(issueStage, issueK) : '0;
    end

    // Counters, bank select and registered read-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q      <= '0;
            k_q          <= '0;
            drainCnt_q   <= '0;
            rdBank_q     <= 1'b0;
            resultBank_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rdEn_q       <= 1'b0;
            rdAddrP_q    <= '0;
            rdAddrQ_q    <= '0;
            twAddr_q     <= '0;
        end else begin
            stage_q      <= stage_d;
            k_q          <= k_d;
            drainCnt_q   <= drainCnt_d;
            rdBank_q     <= rdBank_d;
            resultBank_q <= resultBank_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rdEn_q       <= rdEn_d;
            rdAddrP_q    <= rdAddrP_d;
            rdAddrQ_q    <= rdAddrQ_d;
            twAddr_q     <= twAddr_d;
        end
    end

    // Delay lines that line up butterfly enable and write-back with the read issue; reset empties them so no stale write escapes
    always_ff @(posedge clk) begin
        if (rst) begin
            rdEnPipe_q <= '0;
            for (int i = 0; i < L; i++) begin
                addrPPipe_q[i] <= '0;
                addrQPipe_q[i] <= '0;
            end
        end else begin
            rdEnPipe_q     <= {rdEnPipe_q[L-2:0], rdEn_q};
            addrPPipe_q[0] <= rdAddrP_q;
            addrQPipe_q[0] <= rdAddrQ_q;
            for (int i = 1; i < L; i++) begin
                addrPPipe_q[i] <= addrPPipe_q[i-1];
                addrQPipe_q[i] <= addrQPipe_q[i-1];
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result_bank = resultBank_q;
    assign bus.stage       = stage_q;
    assign bus.rd_en       = rdEn_q;
    assign bus.rd_bank     = rdBank_q;
    assign bus.rd_addr_p   = rdAddrP_q;
    assign bus.rd_addr_q   = rdAddrQ_q;
    assign bus.tw_addr     = twAddr_q;
    assign bus.bf_en       = rdEnPipe_q[RD_LAT-1];
    assign bus.wr_en       = rdEnPipe_q[L-1];
    assign bus.wr_addr_p   = addrPPipe_q[L-1];
    assign bus.wr_addr_q   = addrQPipe_q[L-1];

endmodule

// File: tb/tb_fft_stage_sched.sv
// Scoreboard bench for fft_stage_sched. It uses an 8-point instance and a 16-point
// instance, and only one of the two runs at any time.
// Stimulus pushes hand-tabulated read/write/done/busy expectations, each with its
// cycle number. Negedge monitors pop those expectations and compare them against
// the DUT outputs.
module tb_fft_stage_sched;

    localparam int L = 4;

    logic clk;
    logic rst;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    fft_stage_sched_if #(.LOG2N(3)) bus3();
    fft_stage_sched_if #(.LOG2N(4)) bus4();

    fft_stage_sched #(.LOG2N(3), .RD_LAT(1), .BFLY_LAT(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    fft_stage_sched #(.LOG2N(4), .RD_LAT(1), .BFLY_LAT(3)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    typedef struct {
        int cyc;
        int p;
        int q;
        int tw;
        int bank;
        int stage;
    } rdExp_t;

    typedef struct {
        int cyc;
        int p;
        int q;
    } wrExp_t;

    typedef struct {
        int cyc;
        int bank;
    } doneExp_t;

    rdExp_t   rdQ[$];
    wrExp_t   wrQ[$];
    doneExp_t doneQ[$];
    int       busyQ[$];
    int       bfPend[$];
    int       busyCnt[2];

    // Hand-derived operand tables, listed per stage and per pair
    int p8[12]   = '{0,2,4,6, 0,1,4,5, 0,1,2,3};
    int tw8[12]  = '{0,0,0,0, 0,2,0,2, 0,1,2,3};
    int p16[32]  = '{0,2,4,6,8,10,12,14, 0,1,4,5,8,9,12,13, 0,1,2,3,8,9,10,11, 0,1,2,3,4,5,6,7};
    int tw16[32] = '{0,0,0,0,0,0,0,0, 0,4,0,4,0,4,0,4, 0,2,4,6,0,2,4,6, 0,1,2,3,4,5,6,7};

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter, used to stamp expected and observed events
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic setStart(input int id, input logic v);
        if (id == 0) bus3.start = v;
        else         bus4.start = v;
    endtask

    task automatic pushRun(input int id, input int e0);
        int logn;
        int half;
        rdExp_t r;
        wrExp_t w;
        doneExp_t d;
        logn = (id == 0) ? 3 : 4;
        half = 1 << (logn - 1);
        for (int s = 0; s < logn; s++) begin
            for (int k = 0; k < half; k++) begin
                r.cyc   = e0 + s * (half + L) + k;
                r.p     = (id == 0) ? p8[s*half+k]  : p16[s*half+k];
                r.tw    = (id == 0) ? tw8[s*half+k] : tw16[s*half+k];
                r.q     = r.p + (1 << s);
                r.bank  = s % 2;
                r.stage = s;
                rdQ.push_back(r);
                w.cyc = r.cyc + L;
                w.p   = r.p;
                w.q   = r.q;
                wrQ.push_back(w);
            end
        end
        d.cyc  = e0 + logn * (half + L);
        d.bank = logn % 2;
        doneQ.push_back(d);
        busyQ.push_back(logn * (half + L) + 1);
    endtask

    task automatic flushAll();
        rdQ.delete();
        wrQ.delete();
        doneQ.delete();
        busyQ.delete();
        bfPend.delete();
        busyCnt[0] = 0;
        busyCnt[1] = 0;
    endtask

    task automatic observe(input int id, input logic rdEn, input int p, input int q,
                           input int tw, input int bank, input int stg,
                           input logic bfEn, input logic wrEn, input int wp, input int wq,
                           input logic busyV, input logic doneV, input int resBank);
        rdExp_t r;
        wrExp_t w;
        doneExp_t d;
        int b;
        if (rdEn === 1'b1) begin
            if (rdQ.size() == 0) begin
                checkOutput("rdUnexpected", int'(rdEn), 0);
            end else begin
                r = rdQ.pop_front();
                checkOutput("rdCycle", cyc, r.cyc);
                checkOutput("rdAddrP", p, r.p);
                checkOutput("rdAddrQ", q, r.q);
                checkOutput("twAddr", tw, r.tw);
                checkOutput("rdBank", bank, r.bank);
                checkOutput("stage", stg, r.stage);
            end
            bfPend.push_back(cyc);
        end
        if (bfEn === 1'b1) begin
            if (bfPend.size() == 0) checkOutput("bfUnexpected", int'(bfEn), 0);
            else                    checkOutput("bfAlign", cyc, bfPend.pop_front() + 1);
        end
        if (wrEn === 1'b1) begin
            if (wrQ.size() == 0) begin
                checkOutput("wrUnexpected", int'(wrEn), 0);
            end else begin
                w = wrQ.pop_front();
                checkOutput("wrCycle", cyc, w.cyc);
                checkOutput("wrAddrP", wp, w.p);
                checkOutput("wrAddrQ", wq, w.q);
            end
        end
        if (doneV === 1'b1) begin
            if (doneQ.size() == 0) begin
                checkOutput("doneUnexpected", int'(doneV), 0);
            end else begin
                d = doneQ.pop_front();
                checkOutput("doneCycle", cyc, d.cyc);
                checkOutput("resultBank", resBank, d.bank);
            end
        end
        if (busyV === 1'b1) begin
            busyCnt[id]++;
        end else if (busyCnt[id] != 0) begin
            if (busyQ.size() == 0) begin
                checkOutput("busyUnexpected", busyCnt[id], 0);
            end else begin
                b = busyQ.pop_front();
                checkOutput("busyLength", busyCnt[id], b);
            end
            busyCnt[id] = 0;
        end
    endtask

    // Monitor for the 8-point instance
    always @(negedge clk) begin
        observe(0, bus3.rd_en, int'(bus3.rd_addr_p), int'(bus3.rd_addr_q), int'(bus3.tw_addr),
                int'(bus3.rd_bank), int'(bus3.stage), bus3.bf_en, bus3.wr_en,
                int'(bus3.wr_addr_p), int'(bus3.wr_addr_q), bus3.busy, bus3.done,
                int'(bus3.result_bank));
    end

    // Monitor for the 16-point instance
    always @(negedge clk) begin
        observe(1, bus4.rd_en, int'(bus4.rd_addr_p), int'(bus4.rd_addr_q), int'(bus4.tw_addr),
                int'(bus4.rd_bank), int'(bus4.stage), bus4.bf_en, bus4.wr_en,
                int'(bus4.wr_addr_p), int'(bus4.wr_addr_q), bus4.busy, bus4.done,
                int'(bus4.result_bank));
    end

    task automatic checkAllZero(input string name);
        checkOutput({name, "_n8"}, int'({bus3.busy, bus3.done, bus3.result_bank, bus3.stage,
                    bus3.rd_en, bus3.rd_bank, bus3.rd_addr_p, bus3.rd_addr_q, bus3.tw_addr,
                    bus3.bf_en, bus3.wr_en, bus3.wr_addr_p, bus3.wr_addr_q}), 0);
        checkOutput({name, "_n16"}, int'({bus4.busy, bus4.done, bus4.result_bank, bus4.stage,
                    bus4.rd_en, bus4.rd_bank, bus4.rd_addr_p, bus4.rd_addr_q, bus4.tw_addr,
                    bus4.bf_en, bus4.wr_en, bus4.wr_addr_p, bus4.wr_addr_q}), 0);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic checkDrained();
        checkOutput("rdLeftover", rdQ.size(), 0);
        checkOutput("wrLeftover", wrQ.size(), 0);
        checkOutput("doneLeftover", doneQ.size(), 0);
        checkOutput("busyLeftover", busyQ.size(), 0);
        checkOutput("bfLeftover", bfPend.size(), 0);
    endtask

    // Single-cycle start pulse. The expected run is stamped relative to the edge that samples start.
    task automatic applyStimulus(input int id);
        @(posedge clk);
        #2;
        setStart(id, 1'b1);
        pushRun(id, cyc + 1);
        @(posedge clk);
        #2;
        setStart(id, 1'b0);
    endtask

    initial begin
        int e0;
        rst = 1'b1;
        bus3.start = 1'b0;
        bus4.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        $display("[TB] reset/idle check");
        repeat (10) begin
            @(negedge clk);
            checkAllZero("idleZero");
        end

        $display("[TB] 8-point stage sequence and alignment");
        applyStimulus(0);
        waitCycles(30);
        checkDrained();
        checkOutput("resultBankHold", int'(bus3.result_bank), 1);
        checkOutput("stageHold", int'(bus3.stage), 2);
        checkOutput("busyIdle", int'(bus3.busy), 0);

        $display("[TB] start held, re-pulsed, and asserted in the done cycle");
        @(posedge clk);
        #2;
        setStart(0, 1'b1);
        e0 = cyc + 1;
        pushRun(0, e0);
        repeat (20) begin
            @(posedge clk);
            #2;
        end
        setStart(0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        setStart(0, 1'b1);
        @(posedge clk);
        #2;
        setStart(0, 1'b0);
        while (cyc < e0 + 24) begin
            @(posedge clk);
            #2;
        end
        setStart(0, 1'b1);
        @(posedge clk);
        #2;
        pushRun(0, cyc + 1);
        @(posedge clk);
        #2;
        setStart(0, 1'b0);
        waitCycles(30);
        checkDrained();

        $display("[TB] reset during stage-1 issue");
        @(posedge clk);
        #2;
        setStart(0, 1'b1);
        e0 = cyc + 1;
        pushRun(0, e0);
        @(posedge clk);
        #2;
        setStart(0, 1'b0);
        while (cyc < e0 + 9) begin
            @(posedge clk);
            #2;
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        flushAll();
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        checkAllZero("afterReset");
        waitCycles(12);
        checkDrained();
        applyStimulus(0);
        waitCycles(30);
        checkDrained();

        $display("[TB] 16-point run");
        applyStimulus(1);
        waitCycles(56);
        checkDrained();
        checkOutput("resultBank16Hold", int'(bus4.result_bank), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
